// File: rtl/cordic_dir_encoder.sv
// Iterative vectoring CORDIC: one shared add/shift datapath, seven micro-rotations.
// Produces the rotation chain's direction word plus a scaled magnitude.
module cordic_dir_encoder #(
    parameter int WIDTH = 16,
    parameter int ITER  = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trans_in,
    input  logic signed [WIDTH-1:0] X_in,
    input  logic signed [WIDTH-1:0] Y_in,
    output logic                    busy,
    output logic                    trans_out,
    output logic [ITER+2:0]         index_cor,
    output logic [WIDTH-1:0]        mag
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] w_x_nxt;
    logic signed [WIDTH-1:0] w_y_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [ITER-1:0]        r_dir;
    logic [ITER-1:0]        w_dir_nxt;
    logic                   r_f9;
    logic                   r_f8;
    logic                   r_f7;
    logic                   w_f9_nxt;
    logic                   w_f8_nxt;
    logic                   w_f7_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_tout;
    logic                   w_tout_nxt;
    logic [ITER+2:0]        r_index;
    logic [ITER+2:0]        w_index_nxt;
    logic [WIDTH-1:0]       r_mag;
    logic [WIDTH-1:0]       w_mag_nxt;

    // Clamp a WIDTH+1 bit sum back into the signed WIDTH range
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] s);
        logic [WIDTH-1:0] v;
        if (s[WIDTH] != s[WIDTH-1]) begin
            v = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            v = s[WIDTH-1:0];
        end
        return v;
    endfunction

    logic signed [WIDTH-1:0] w_xsh;
    logic signed [WIDTH-1:0] w_ysh;
    logic signed [WIDTH:0]   w_xe;
    logic signed [WIDTH:0]   w_ye;
    logic signed [WIDTH:0]   w_xshe;
    logic signed [WIDTH:0]   w_yshe;
    logic signed [WIDTH:0]   w_xsum;
    logic signed [WIDTH:0]   w_ysum;
    logic signed [WIDTH:0]   w_xneg;
    logic signed [WIDTH:0]   w_yneg;
    logic                    w_d;
    logic                    w_last;

    assign w_xsh  = r_x >>> r_cnt;
    assign w_ysh  = r_y >>> r_cnt;
    assign w_xe   = {r_x[WIDTH-1], r_x};
    assign w_ye   = {r_y[WIDTH-1], r_y};
    assign w_xshe = {w_xsh[WIDTH-1], w_xsh};
    assign w_yshe = {w_ysh[WIDTH-1], w_ysh};
    assign w_d    = ~r_y[WIDTH-1];
    assign w_last = (r_cnt == CW'(ITER - 1));

    // Rotate toward the X axis; both updates read the pre-rotation X and Y
    assign w_xsum = w_d ? (w_xe + w_yshe) : (w_xe - w_yshe);
    assign w_ysum = w_d ? (w_ye - w_xshe) : (w_ye + w_xshe);
    assign w_xneg = '0 - w_xe;
    assign w_yneg = '0 - w_ye;

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_f9_nxt    = r_f9;
        w_f8_nxt    = r_f8;
        w_f7_nxt    = r_f7;
        w_busy_nxt  = r_busy;
        w_tout_nxt  = 1'b0;
        w_index_nxt = r_index;
        w_mag_nxt   = r_mag;
        unique case (r_state)
            S_IDLE: begin
                if (trans_in) begin
                    w_x_nxt     = X_in;
                    w_y_nxt     = Y_in;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                w_f9_nxt = r_x[WIDTH-1];
                w_f8_nxt = r_y[WIDTH-1];
                w_f7_nxt = (r_x == '0) && (r_y == '0);
                if (r_x[WIDTH-1]) begin
                    w_x_nxt = sat(w_xneg);
                    w_y_nxt = sat(w_yneg);
                end
                w_cnt_nxt   = '0;
                w_dir_nxt   = '0;
                w_state_nxt = S_ITER;
            end
            S_ITER: begin
                w_x_nxt   = sat(w_xsum);
                w_y_nxt   = sat(w_ysum);
                // First decision lands in the MSB after all shifts
                w_dir_nxt = {r_dir[ITER-2:0], w_d};
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_index_nxt = {r_f9, r_f8, r_f7, r_dir};
                w_mag_nxt   = r_x;
                w_tout_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
            r_dir   <= '0;
            r_f9    <= 1'b0;
            r_f8    <= 1'b0;
            r_f7    <= 1'b0;
            r_busy  <= 1'b0;
            r_tout  <= 1'b0;
            r_index <= '0;
            r_mag   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_f9    <= w_f9_nxt;
            r_f8    <= w_f8_nxt;
            r_f7    <= w_f7_nxt;
            r_busy  <= w_busy_nxt;
            r_tout  <= w_tout_nxt;
            r_index <= w_index_nxt;
            r_mag   <= w_mag_nxt;
        end
    end

    assign busy      = r_busy;
    assign trans_out = r_tout;
    assign index_cor = r_index;
    assign mag       = r_mag;

endmodule

// File: tb/tb_cordic_dir_encoder.sv
// Directed bench for cordic_dir_encoder with an expected-result queue.
// Expected words/magnitudes were worked out by hand from the CORDIC recurrence.
module tb_cordic_dir_encoder;

    typedef struct packed {
        logic [9:0]  idx;
        logic [15:0] mg;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               trans_in = 1'b0;
    logic signed [15:0] X_in = '0;
    logic signed [15:0] Y_in = '0;
    logic               busy;
    logic               trans_out;
    logic [9:0]         index_cor;
    logic [15:0]        mag;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cordic_dir_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .trans_in  (trans_in),
        .X_in      (X_in),
        .Y_in      (Y_in),
        .busy      (busy),
        .trans_out (trans_out),
        .index_cor (index_cor),
        .mag       (mag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one start strobe across edge E0; optionally log its expectation
    task automatic start(input string tag, input logic signed [15:0] x,
                         input logic signed [15:0] y, input logic [9:0] idx,
                         input logic [15:0] mg, input bit push);
        exp_t e;
        X_in     = x;
        Y_in     = y;
        trans_in = 1'b1;
        if (push) begin
            e.idx = idx;
            e.mg  = mg;
            q.push_back(e);
        end
        tick();
        trans_in = 1'b0;
        chk({tag, "_busy_acc"}, busy, 1);
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        bit   seen;
        int   lat;
        int   idle_busy;
        exp_t e;
        seen      = 1'b0;
        lat       = 0;
        idle_busy = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            lat++;
            if (trans_out) seen = 1'b1;
            else if (!busy) idle_busy++;
        end
        chk({tag, "_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_lat"}, lat, exp_lat);
            chk({tag, "_busy_hi"}, idle_busy, 0);
            chk({tag, "_busy_lo"}, busy, 0);
            chk({tag, "_sb"}, q.size(), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({tag, "_idx"}, index_cor, e.idx);
                chk({tag, "_mag"}, mag, e.mg);
            end
        end
    endtask

    task automatic count_pulses(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (trans_out) p++;
        end
    endtask

    task automatic vec(input string tag, input logic signed [15:0] x,
                       input logic signed [15:0] y, input logic [9:0] idx,
                       input logic [15:0] mg);
        start(tag, x, y, idx, mg, 1'b1);
        wait_result(tag, 9);
        tick();
        chk({tag, "_tout_drop"}, trans_out, 0);
        chk({tag, "_idx_hold"}, index_cor, idx);
        chk({tag, "_mag_hold"}, mag, mg);
    endtask

    initial begin
        int p;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_tout", trans_out, 0);
        chk("rst_idx", index_cor, 0);
        chk("rst_mag", mag, 0);
        count_pulses(5, p);
        chk("idle_pulses", p, 0);

        vec("pos_x", 16'sd1000, 16'sd0, 10'h045, 16'd1646);
        vec("neg_x", -16'sd1000, 16'sd0, 10'h245, 16'd1646);
        vec("zero", 16'sd0, 16'sd0, 10'h0FF, 16'd0);
        vec("min_x", -16'sd32768, 16'sd0, 10'h240, 16'd32767);
        vec("pos_y", 16'sd0, 16'sd1000, 10'h07A, 16'd1646);
        vec("neg_y", 16'sd0, -16'sd1000, 10'h105, 16'd1646);

        // Strobe at E4 must be dropped; strobe in the result cycle is taken
        start("ign", 16'sd0, 16'sd1000, 10'h07A, 16'd1646, 1'b1);
        tick();
        tick();
        tick();
        X_in     = -16'sd1000;
        Y_in     = 16'sd0;
        trans_in = 1'b1;
        tick();
        trans_in = 1'b0;
        chk("ign_busy_e4", busy, 1);
        wait_result("ign", 5);
        start("b2b", 16'sd0, -16'sd1000, 10'h105, 16'd1646, 1'b1);
        wait_result("b2b", 9);
        count_pulses(12, p);
        chk("ign_extra_pulses", p, 0);
        chk("ign_sb_empty", q.size(), 0);

        // Abort at E5 by reset, then a clean vector
        start("abort", 16'sd1000, 16'sd0, 10'h045, 16'd1646, 1'b0);
        tick();
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_tout", trans_out, 0);
        chk("abort_idx", index_cor, 0);
        chk("abort_mag", mag, 0);
        count_pulses(12, p);
        chk("abort_pulses", p, 0);
        vec("after", -16'sd1000, 16'sd0, 10'h245, 16'd1646);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cordic_dir_encoder.md
Name: cordic_dir_encoder

Overview:
- Iterative vectoring CORDIC that turns a 16-bit (X,Y) vector into the 10-bit direction word (index_cor) and a magnitude.
- The index_cor word is consumed by the pipelined CORDIC rotation chain, so this block is the encoding end of that interface.
- A single datapath is reused over 7 micro-rotations under an FSM.
- A trans_in / trans_out strobe pair matches the rotation chain's handshake.

Parameters:
- WIDTH, 16, datapath width (two's complement). Only 16 is verified.
- ITER, 7, number of micro-rotations. The index width is ITER+3 = 10.

Ports:
- clk        input   1   rising-edge clock
- reset      input   1   synchronous, active-low reset
- trans_in   input   1   start strobe; sampled only while busy=0
- X_in       input   16  signed X of the input vector
- Y_in       input   16  signed Y of the input vector
- busy       output  1   high while a vector is in flight
- trans_out  output  1   one-cycle result-valid pulse
- index_cor  output  10  direction word: [9:7] quadrant/flags, [6:0] micro-rotation directions
- mag        output  16  final X residue (scaled magnitude), non-negative

Behaviour:
- Reset: on a clk edge with reset=0:
  - state=IDLE; busy=0, trans_out=0, index_cor=0, mag=0; internal X, Y and count cleared.
  - Reset overrides everything, including mid-operation. An in-flight vector is discarded and no trans_out is produced.
- FSM states: IDLE, PRE, ITER, DONE.
- IDLE:
  - If trans_in=1 at edge E0: latch X_in and Y_in, go to PRE, busy=1.
  - trans_in while busy=1 is ignored; no queueing.
- PRE (edge E1): set the flags, pre-rotate, set count=0, go to ITER.
  - flag9 = (X<0).
  - flag8 = (Y<0).
  - flag7 = (X==0 && Y==0).
  - If X<0, negate both X and Y. Negation saturates: -(-32768) = 32767.
- ITER (edges E2..E8, count i = 0..6), with S = sign(Y):
  - If Y>=0: d=1, X' = X + (Y>>>i), Y' = Y - (X>>>i).
  - If Y<0: d=0, X' = X - (Y>>>i), Y' = Y + (X>>>i).
  - Shifts are arithmetic (floor). Both updates use the old X and Y.
  - Sums are formed at 17 bits and saturated to [-32768, 32767].
  - d is stored into index bit (6-i).
  - At i=6, go to DONE.
- DONE (edge E9):
  - Register index_cor = {flag9, flag8, flag7, d[6:0]} and mag = X.
  - trans_out=1, busy=0, go to IDLE.
- Latency and throughput:
  - trans_out is high for exactly the one cycle following E9, i.e. 9 clocks after acceptance.
  - busy is low in that same cycle, so a new trans_in there is accepted at E10. Throughput is 1 vector per 10 clocks.
- Output holding:
  - trans_out returns to 0 on the next edge.
  - index_cor and mag hold their value until the next DONE or a reset.
- Zero vector: Y stays 0, so every d=1 and [6:0] = 7'h7F.
- Y residue is not output.

Test Plan:
- Reset low for 2 cycles, then release -> busy=0, trans_out=0, index_cor=0, mag=0. No trans_out while idle.
- X_in=1000, Y_in=0, trans_in pulse at E0 -> trans_out pulses after E9 with index_cor=10'h045 and mag=1646. busy is high during the 9 preceding cycles.
- X_in=-1000, Y_in=0 -> index_cor=10'h245, mag=1646. X_in=0, Y_in=0 -> index_cor=10'h0FF, mag=0.
- X_in=-32768, Y_in=0 -> negation saturates and X stays clamped. index_cor=10'h240, mag=32767; mag never wraps negative.
- Second trans_in asserted at E4 with different data -> ignored; only one trans_out, carrying the first vector's result. A trans_in in the trans_out cycle is accepted, and its result appears 10 clocks after the first result.
- reset=0 at E5 mid-operation, then a fresh start -> no trans_out from the aborted vector; outputs are 0 and the following vector completes normally.
